// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU-drive and response signals of the two-port ALU arbiter.
// Requester slices are packed; slice i (bits i*n +: n, or i*3 / i*2 for codes) belongs to requester i.
// The "master" side is the requester/consumer/ALU environment; "slave" is the arbiter.
interface alu_arbiter_if #(
    parameter int n = 8
);
    // Requests
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*n-1:0] req_a;
    logic [2*n-1:0] req_b;
    logic [5:0]     req_func;
    logic [3:0]     req_a_sel;
    logic [3:0]     req_b_sel;
    logic [2*n-1:0] req_imm;
    logic [1:0]     req_lock;

    // Shared ALU
    logic [n-1:0]   alu_a_in;
    logic [n-1:0]   alu_b_in;
    logic [n-1:0]   alu_immediate;
    logic [2:0]     alu_func;
    logic [1:0]     alu_a_sel;
    logic [1:0]     alu_b_sel;
    logic [n-1:0]   alu_result;
    logic [3:0]     alu_flags;

    // Response
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [n-1:0]   rsp_result;
    logic [3:0]     rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_func, req_a_sel, req_b_sel, req_imm, req_lock,
        output req_ready,
        output alu_a_in, alu_b_in, alu_immediate, alu_func, alu_a_sel, alu_b_sel,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_id, rsp_result, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_func, req_a_sel, req_b_sel, req_imm, req_lock,
        input  req_ready,
        input  alu_a_in, alu_b_in, alu_immediate, alu_func, alu_a_sel, alu_b_sel,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one combinational picoMIPS ALU.
// The granted requester's operands drive the ALU; the result and flags are captured
// into a one-entry valid/ready response register tagged with the requester id.
// Optional feature: define ALU_ARB_LOCK_EN to let a requester hold the ALU across
// several operations (req_lock); without it req_lock is ignored.
module alu_arbiter #(
    parameter int n = 8
) (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave bus
);
    localparam logic [2:0] RA  = 3'd0;
    localparam logic [1:0] REG = 2'd0;

    logic         slot_free;
    logic [1:0]   eligible;
    logic         grant_valid;
    logic         grant_id;
    logic         last_grant;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [n-1:0] rsp_result_q;
    logic [3:0]   rsp_flags_q;

`ifdef ALU_ARB_LOCK_EN
    logic         lock_active;
    logic         lock_owner;
`else
    logic         unused_lock;
    assign unused_lock = ^bus.req_lock;
`endif

    // Pick at most one requester: lock owner only while locked, otherwise round-robin on ties.
    always_comb begin
        eligible = bus.req_valid;
`ifdef ALU_ARB_LOCK_EN
        if (lock_active) begin
            eligible = lock_owner ? (bus.req_valid & 2'b10) : (bus.req_valid & 2'b01);
        end
`endif
        slot_free   = !rsp_valid_q || bus.rsp_ready;
        grant_valid = slot_free && (eligible != '0);
        case (eligible)
            2'b11:   grant_id = ~last_grant;
            2'b10:   grant_id = 1'b1;
            default: grant_id = 1'b0;
        endcase
        bus.req_ready = '0;
        if (grant_valid) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    // Steer the granted requester's slices onto the ALU; idle drive is RA with REG selects and zero operands.
    always_comb begin
        bus.alu_a_in      = '0;
        bus.alu_b_in      = '0;
        bus.alu_immediate = '0;
        bus.alu_func      = RA;
        bus.alu_a_sel     = REG;
        bus.alu_b_sel     = REG;
        if (grant_valid) begin
            bus.alu_a_in      = grant_id ? bus.req_a[2*n-1:n]   : bus.req_a[n-1:0];
            bus.alu_b_in      = grant_id ? bus.req_b[2*n-1:n]   : bus.req_b[n-1:0];
            bus.alu_immediate = grant_id ? bus.req_imm[2*n-1:n] : bus.req_imm[n-1:0];
            bus.alu_func      = grant_id ? bus.req_func[5:3]    : bus.req_func[2:0];
            bus.alu_a_sel     = grant_id ? bus.req_a_sel[3:2]   : bus.req_a_sel[1:0];
            bus.alu_b_sel     = grant_id ? bus.req_b_sel[3:2]   : bus.req_b_sel[1:0];
        end
    end

    // Capture the ALU output on a transfer; drain the response when consumed with nothing new arriving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            last_grant   <= 1'b1;
        end else if (grant_valid) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= grant_id;
            rsp_result_q <= bus.alu_result;
            rsp_flags_q  <= bus.alu_flags;
            last_grant   <= grant_id;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    // While locked only the owner can be granted, so each owner transfer simply rewrites the lock
    // from its req_lock bit: 1 keeps/takes the lock, 0 releases it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
        end else if (grant_valid) begin
            lock_active <= bus.req_lock[grant_id];
            lock_owner  <= grant_id;
        end
    end
`endif

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scenario tasks for alu_arbiter with a behavioural ALU and a response scoreboard.
// Grant expectations for the lock scenario follow ALU_ARB_LOCK_EN.
module tb_alu_arbiter;
    localparam int N = 8;
    localparam logic [2:0] RA = 3'd0, RB = 3'd1, RADD = 3'd2, RSUB = 3'd3, RMULL = 3'd4;
    localparam logic [1:0] REG = 2'd0, IMM = 2'd3;

    typedef struct packed {
        logic         id;
        logic [N-1:0] result;
        logic [3:0]   flags;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    rsp_t got, exp;

    alu_arbiter_if #(.n(N)) bus ();

    alu_arbiter #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU (switch inputs absent, so SW selects read as zero); flags are {V,N,Z,C}.
    logic [N-1:0] a_op, b_op, r;
    logic [N:0]   s;
    logic [2*N-1:0] p;
    logic         c, v;
    always_comb begin
        a_op = (bus.alu_a_sel == IMM) ? bus.alu_immediate : (bus.alu_a_sel == REG) ? bus.alu_a_in : '0;
        b_op = (bus.alu_b_sel == IMM) ? bus.alu_immediate : (bus.alu_b_sel == REG) ? bus.alu_b_in : '0;
        s = '0;
        p = '0;
        c = 1'b0;
        v = 1'b0;
        r = a_op;
        case (bus.alu_func)
            RB:    r = b_op;
            RADD:  begin s = {1'b0, a_op} + {1'b0, b_op}; r = s[N-1:0]; c = s[N];
                         v = (a_op[N-1] == b_op[N-1]) && (r[N-1] != a_op[N-1]); end
            RSUB:  begin s = {1'b0, a_op} - {1'b0, b_op}; r = s[N-1:0]; c = s[N];
                         v = (a_op[N-1] != b_op[N-1]) && (r[N-1] != a_op[N-1]); end
            RMULL: begin p = {{N{1'b0}}, a_op} * {{N{1'b0}}, b_op}; r = p[N-1:0]; end
            default: r = a_op;
        endcase
        bus.alu_result = r;
        bus.alu_flags  = {v, r[N-1], (r == '0), c};
    end

    // Scoreboard: every consumed response must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            got = {bus.rsp_id, bus.rsp_result, bus.rsp_flags};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected: got id=%0d result=%h flags=%b, required no response",
                         got.id, got.result, got.flags);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL scoreboard_rsp: got id=%0d result=%h flags=%b, required id=%0d result=%h flags=%b",
                             got.id, got.result, got.flags, exp.id, exp.result, exp.flags);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic valid, input logic [2:0] func,
                           input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [1:0] asel, input logic [1:0] bsel,
                           input logic [N-1:0] imm, input logic lock);
        bus.req_valid[i]        = valid;
        bus.req_func[i*3 +: 3]  = func;
        bus.req_a[i*N +: N]     = a;
        bus.req_b[i*N +: N]     = b;
        bus.req_a_sel[i*2 +: 2] = asel;
        bus.req_b_sel[i*2 +: 2] = bsel;
        bus.req_imm[i*N +: N]   = imm;
        bus.req_lock[i]         = lock;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_imm = '0;
        bus.req_func = '0; bus.req_a_sel = '0; bus.req_b_sel = '0; bus.req_lock = '0;
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags} !== '0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b id=%b result=%h flags=%b, required all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags);
        end
        checks++;
        if (bus.req_ready !== 2'b00 || bus.alu_func !== RA || bus.alu_a_sel !== REG || bus.alu_b_sel !== REG
            || bus.alu_a_in !== '0 || bus.alu_b_in !== '0 || bus.alu_immediate !== '0) begin
            failures++;
            $display("FAIL reset_idle_drive: got ready=%b func=%0d asel=%0d bsel=%0d a=%h b=%h imm=%h, required 00/RA/REG/REG/0/0/0",
                     bus.req_ready, bus.alu_func, bus.alu_a_sel, bus.alu_b_sel, bus.alu_a_in, bus.alu_b_in, bus.alu_immediate);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_single_add();
        set_req(0, 1'b1, RADD, 8'h7F, 8'h01, REG, REG, 8'h00, 1'b0);
        bus.rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h80, 4'b1100});
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL add_ready: got %b, required 01", bus.req_ready);
        end
        checks++;
        if (bus.alu_func !== RADD || bus.alu_a_in !== 8'h7F || bus.alu_b_in !== 8'h01) begin
            failures++;
            $display("FAIL add_alu_drive: got func=%0d a=%h b=%h, required 2/7f/01", bus.alu_func, bus.alu_a_in, bus.alu_b_in);
        end
        step();
        set_req(0, 1'b0, RA, 8'h00, 8'h00, REG, REG, 8'h00, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_latency: got rsp_valid=%b, required 1", bus.rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_drain: got rsp_valid=%b, required 0", bus.rsp_valid);
        end
        step();
    endtask

    task automatic test_contention();
        pulse_reset();
        set_req(0, 1'b1, RSUB, 8'h05, 8'h05, REG, REG, 8'h00, 1'b0);
        set_req(1, 1'b1, RMULL, 8'h10, 8'h10, REG, REG, 8'h00, 1'b0);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({i[0], 8'h00, 4'b0010});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== (i[0] ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got %b, required %b", i, bus.req_ready, i[0] ? 2'b10 : 2'b01);
            end
            if (i > 0) begin
                checks++;
                if (bus.rsp_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL contention_throughput[%0d]: got rsp_valid=%b, required 1", i, bus.rsp_valid);
                end
            end
            step();
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL contention_drain: got rsp_valid=%b, required 0", bus.rsp_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        set_req(0, 1'b1, RADD, 8'h03, 8'h04, REG, REG, 8'h00, 1'b0);
        bus.rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h07, 4'b0000});
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL bp_first_grant: got %b, required 01", bus.req_ready);
        end
        step();
        bus.req_valid[0] = 1'b0;
        set_req(1, 1'b1, RB, 8'h00, 8'h5A, REG, REG, 8'h00, 1'b0);
        exp_q.push_back({1'b1, 8'h5A, 4'b0000});
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 2'b00) begin
                failures++;
                $display("FAIL bp_stall_ready[%0d]: got %b, required 00", k, bus.req_ready);
            end
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 8'h07 || bus.rsp_flags !== 4'b0000) begin
                failures++;
                $display("FAIL bp_stall_hold[%0d]: got valid=%b id=%b result=%h flags=%b, required 1/0/07/0000",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_release_grant: got %b, required 10", bus.req_ready);
        end
        step();
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL bp_next_rsp: got valid=%b id=%b, required 1/1", bus.rsp_valid, bus.rsp_id);
        end
        step();
        step();
    endtask

    task automatic test_immediate();
        set_req(1, 1'b1, RADD, 8'h01, 8'h22, REG, IMM, 8'hFF, 1'b0);
        bus.rsp_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h00, 4'b0011});
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b10 || bus.alu_immediate !== 8'hFF || bus.alu_b_sel !== IMM) begin
            failures++;
            $display("FAIL imm_drive: got ready=%b imm=%h bsel=%0d, required 10/ff/3", bus.req_ready, bus.alu_immediate, bus.alu_b_sel);
        end
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        step();
        step();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, RADD, 8'h7F, 8'h01, REG, REG, 8'h00, 1'b0);
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pending: got rsp_valid=%b, required 1", bus.rsp_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_async_clear: got valid=%b result=%h, required 0/00", bus.rsp_valid, bus.rsp_result);
        end
        step();
        reset = 1'b0;
        set_req(0, 1'b1, RA, 8'h11, 8'h00, REG, REG, 8'h00, 1'b0);
        set_req(1, 1'b1, RA, 8'h22, 8'h00, REG, REG, 8'h00, 1'b0);
        bus.rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h11, 4'b0000});
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_tie_priority: got %b, required 01", bus.req_ready);
        end
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        step();
        step();
    endtask

    task automatic test_lock();
        logic [3:0] grant_seq;
        int n0;
`ifdef ALU_ARB_LOCK_EN
        grant_seq = 4'b1000;
`else
        grant_seq = 4'b1010;
`endif
        n0 = 0;
        pulse_reset();
        set_req(0, 1'b1, RADD, 8'h01, 8'h02, REG, REG, 8'h00, 1'b1);
        set_req(1, 1'b1, RB, 8'h00, 8'h80, REG, REG, 8'h00, 1'b0);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (grant_seq[i]) exp_q.push_back({1'b1, 8'h80, 4'b0100});
            else              exp_q.push_back({1'b0, 8'h03, 4'b0000});
        end
        for (int i = 0; i < 4; i++) begin
            bus.req_lock[0] = (n0 < 2);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== (grant_seq[i] ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL lock_grant[%0d]: got %b, required %b", i, bus.req_ready, grant_seq[i] ? 2'b10 : 2'b01);
            end
            if (bus.req_ready[0]) n0++;
            step();
        end
        bus.req_valid = 2'b00;
        bus.req_lock  = 2'b00;
        @(negedge clk);
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_immediate();
        test_reset_mid();
        test_lock();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: got %0d pending responses, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single combinational picoMIPS `alu` between two requesters, e.g. the core datapath and a coprocessor/debug port. Each cycle at most one request is granted and its operands, function code and operand selects are driven onto the ALU. The ALU result and flags are captured into a response register tagged with the requester ID. Response handshake is valid/ready with one-entry buffering.

## Interface
- `n`, 8, operand/result width; the requester count is fixed at 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept, combinational; at most one bit high.
- `req_a`, `req_b`  in  2×n  packed operands; slice i belongs to requester i.
- `req_func`  in  2×3  ALU function code (`RA`, `RB`, `RADD`, `RSUB`, `RMULL`).
- `req_a_sel`, `req_b_sel`  in  2×2  ALU input selects (`REG`, `SW_7_0`, `SW_8`, `IMM`).
- `req_imm`  in  2×n  immediate value.
- `req_lock`  in  2  lock request; used only when `ALU_ARB_LOCK_EN` is defined.
- `alu_a_in`, `alu_b_in`, `alu_immediate`  out  n  driven to the ALU.
- `alu_func`  out  3; `alu_a_sel`, `alu_b_sel`  out  2  driven to the ALU.
- `alu_result`  in  n; `alu_flags`  in  4 (V,N,Z,C)  returned from the ALU.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  1  requester that issued the response.
- `rsp_result`  out  n  captured ALU result.
- `rsp_flags`  out  4  captured ALU flags.

## Operation
- **Slot free** = `!rsp_valid || rsp_ready`.
- **Grant selection.** When a slot is free and any `req_valid` bit is set, exactly one requester is granted.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than `last_grant` is granted.
- **Transfer.** A transfer occurs on requester g when `req_valid[g] && req_ready[g]`; `req_ready[g]` is 1 only for the granted requester.
- **ALU drive during a grant.** The ALU outputs mirror the granted requester's slices.
- **ALU drive with no grant.** `alu_func`=`RA`, both selects=`REG`, all operand outputs 0.
- **On each transfer edge:**
  - `rsp_result`←`alu_result`, `rsp_flags`←`alu_flags`, `rsp_id`←g, `rsp_valid`←1.
  - `last_grant`←g.
- **Response drain.** On `rsp_valid && rsp_ready` with no new transfer in the same cycle, `rsp_valid`←0. With a simultaneous transfer, `rsp_valid` stays 1 and the register is loaded with the new data.
- **Stall.** While `rsp_valid && !rsp_ready`, `req_ready`=0 and the response register holds its value.
- **Internal state.** Response register, `last_grant` (1 bit), and lock state (owner plus active bit).

## Timing
- **Reset values:**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Lock inactive.
- **Latency.** `rsp_valid` rises on the edge following the transfer cycle, which is 1 cycle.
- **Throughput.** One operation per cycle when `rsp_ready` is held high.
- **Combinational paths.** `req_ready` and the `alu_*` outputs depend combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and state. The ALU path is combinational, so the request-to-capture path is a single cycle.
- **Reset mid-operation.** A pending response is dropped, the lock is cleared and grant priority is restored to requester 0. Requesters must re-present operands after reset.
- **Requester holding.** `req_*` slices must be held stable while `req_valid` is high and not yet accepted. A requester may drop `req_valid` before acceptance without effect.

## Configuration
- **`ALU_ARB_LOCK_EN` defined:**
  - A transfer with `req_lock[g]`=1 sets the lock active with owner g.
  - While the lock is active, only the owner may be granted; the other requester sees `req_ready`=0 even if the owner is idle.
  - A transfer by the owner with `req_lock`=0 releases the lock at that edge.
  - The lock supports atomic multi-op sequences such as multiply then add.
- **`ALU_ARB_LOCK_EN` undefined:** `req_lock` is ignored, no lock state is built, and the block is pure round-robin.

## Test plan
- **Single add.** After reset, requester 0 presents `RADD`, a=8'h7F, b=8'h01, `REG`/`REG`, with `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=8'h80, `rsp_flags`=4'b1100.
- **Contention.** Both requesters valid continuously: req0 `RSUB` 5−5, req1 `RMULL` 16×16, `rsp_ready`=1.
  - Grants alternate 0,1,0,1.
  - Each response has `rsp_result`=8'h00 and `rsp_flags`=4'b0010.
- **Backpressure.** Issue one op, then hold `rsp_ready`=0 for 3 cycles while req1 stays valid.
  - `req_ready`=2'b00 and the response is unchanged throughout.
  - Raising `rsp_ready` grants req1 in that same cycle, and the new response appears on the next edge.
- **Immediate select.** req1 issues `RADD` with `b_sel`=`IMM`, imm=8'hFF, a=8'h01 → `rsp_result`=8'h00, `rsp_flags`=4'b0011.
- **Reset mid-operation.** Assert `reset` while `rsp_valid`=1 → `rsp_valid` goes to 0 immediately. After release, a tie grants requester 0 first.
- **Lock (with `ALU_ARB_LOCK_EN`).**
  - req0 issues two locked ops, then one unlocked op, while req1 is valid throughout → grants are 0,0,0,1.
  - Without the macro, the same stimulus gives grants 0,1,0,1.
